// File: rtl/dmac_table_arbiter_pkg.sv
// Shared definitions for the DMAC table arbiter: entry/address widths,
// starve counter width and the config FSM state encoding.
package dmac_table_arbiter_pkg;

    localparam int DMAC_ENTRY_W = 57;
    localparam int DMAC_ADDR_W  = 5;
    localparam int STARVE_CNT_W = 8;

    typedef enum logic [2:0] {
        CFG_IDLE      = 3'd0,
        CFG_WAIT_SLOT = 3'd1,
        CFG_RD_WAIT1  = 3'd2,
        CFG_RD_WAIT2  = 3'd3,
        CFG_ACK       = 3'd4
    } cfg_state_t;

endpackage

// File: rtl/dmac_table_arbiter_rd_tag_pipe.sv
// dmac_rd_tag_pipe: two-stage delay of the "config read issued" flag.
// The RAM returns read data two cycles after the read strobe, so the
// delayed flag marks exactly the cycle in which iv_ram_rdata belongs to
// the config read and must be captured.
module dmac_rd_tag_pipe (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_issue,
    output logic o_capture
);

    logic stage1;

    // Shift the issue flag through two register stages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage1    <= 1'b0;
            o_capture <= 1'b0;
        end else begin
            stage1    <= i_issue;
            o_capture <= stage1;
        end
    end

endmodule

// File: rtl/dmac_table_arbiter.sv
// dmac_table_arbiter: shares one pipelined DMAC RAM port between the
// lookup engine (absolute priority, zero added latency) and a config
// requester that slips into cycles the lookup engine leaves idle.
// Optional feature macro DMAC_ARB_STARVE_EN: starve counter that raises
// o_lookup_block once a config request has waited STARVE_LIMIT cycles.
module dmac_table_arbiter
    import dmac_table_arbiter_pkg::*;
#(
    parameter logic [STARVE_CNT_W-1:0] STARVE_LIMIT = 8'd16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_lu_ram_rd,
    input  logic [DMAC_ADDR_W-1:0]  iv_lu_ram_raddr,
    output logic [DMAC_ENTRY_W-1:0] ov_lu_ram_rdata,
    input  logic                    i_cfg_req,
    input  logic                    i_cfg_wr,
    input  logic [DMAC_ADDR_W-1:0]  iv_cfg_addr,
    input  logic [DMAC_ENTRY_W-1:0] iv_cfg_wdata,
    output logic                    o_cfg_ack,
    output logic [DMAC_ENTRY_W-1:0] ov_cfg_rdata,
    output logic                    o_ram_rd,
    output logic                    o_ram_wr,
    output logic [DMAC_ADDR_W-1:0]  ov_ram_addr,
    output logic [DMAC_ENTRY_W-1:0] ov_ram_wdata,
    input  logic [DMAC_ENTRY_W-1:0] iv_ram_rdata,
    output logic                    o_lookup_block
);

    cfg_state_t              state;
    logic                    cfg_wr_q;
    logic [DMAC_ADDR_W-1:0]  cfg_addr_q;
    logic [DMAC_ENTRY_W-1:0] cfg_wdata_q;
    logic                    cfg_issue;
    logic                    rd_capture;

    // The pipelined RAM keeps lookup and config read data apart in time,
    // so lookup data is simply passed through.
    assign ov_lu_ram_rdata = iv_ram_rdata;

    // A config access may only use a slot the lookup engine leaves free.
    // Reset holds the FSM in CFG_IDLE, so during reset this stays low and
    // the RAM port follows the lookup inputs alone.
    assign cfg_issue = (state == CFG_WAIT_SLOT) && !i_lu_ram_rd;

    // Combinational RAM port mux: lookup by default, config on its slot.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_ram_rd     = i_lu_ram_rd;
        o_ram_wr     = 1'b0;
        ov_ram_addr  = iv_lu_ram_raddr;
        ov_ram_wdata = '0;
        if (cfg_issue) begin
            o_ram_rd     = !cfg_wr_q;
            o_ram_wr     = cfg_wr_q;
            ov_ram_addr  = cfg_addr_q;
            ov_ram_wdata = cfg_wr_q ? cfg_wdata_q : '0;
        end
    end

    dmac_rd_tag_pipe u_rd_tag_pipe (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_issue   (cfg_issue && !cfg_wr_q),
        .o_capture (rd_capture)
    );

    // Config FSM with registered ack and read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= CFG_IDLE;
            cfg_wr_q     <= 1'b0;
            cfg_addr_q   <= '0;
            cfg_wdata_q  <= '0;
            o_cfg_ack    <= 1'b0;
            ov_cfg_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            o_cfg_ack <= 1'b0;
            // Capture lands on the edge that enters CFG_ACK; value then holds.
            if (rd_capture) begin
                ov_cfg_rdata <= iv_ram_rdata;
            end
            case (state)
                CFG_IDLE: begin
                    if (i_cfg_req) begin
                        cfg_wr_q    <= i_cfg_wr;
                        cfg_addr_q  <= iv_cfg_addr;
                        cfg_wdata_q <= iv_cfg_wdata;
                        state       <= CFG_WAIT_SLOT;
                    end
                end
                CFG_WAIT_SLOT: begin
                    if (!i_lu_ram_rd) begin
                        if (cfg_wr_q) begin
                            state     <= CFG_ACK;
                            o_cfg_ack <= 1'b1;
                        end else begin
                            state <= CFG_RD_WAIT1;
                        end
                    end
                end
                CFG_RD_WAIT1: state <= CFG_RD_WAIT2;
                CFG_RD_WAIT2: begin
                    state     <= CFG_ACK;
                    o_cfg_ack <= 1'b1;
                end
                CFG_ACK: state <= CFG_IDLE;
                default: state <= CFG_IDLE;
            endcase
        end
    end

`ifdef DMAC_ARB_STARVE_EN
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [STARVE_CNT_W-1:0] starve_cnt_inc;

    assign starve_cnt_inc = (starve_cnt == '1) ? starve_cnt : starve_cnt + 1'b1;

    // Count waiting cycles; block new lookup searches once the limit is hit.
    // The block is advisory: a lookup burst already running is never gated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt     <= '0;
            o_lookup_block <= 1'b0;
        end else if (cfg_issue) begin
            starve_cnt     <= '0;
            o_lookup_block <= 1'b0;
        end else if (state == CFG_WAIT_SLOT) begin
            starve_cnt <= starve_cnt_inc;
            if (starve_cnt_inc >= STARVE_LIMIT) begin
                o_lookup_block <= 1'b1;
            end
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign o_lookup_block      = 1'b0;
`endif

endmodule

// File: tb/tb_dmac_table_arbiter.sv
// Directed bench for dmac_table_arbiter with a 2-cycle pipelined RAM model.
// Starve-counter scenario is compiled in only with DMAC_ARB_STARVE_EN.
module tb_dmac_table_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lu_rd = 1'b0;
    logic [4:0]  lu_addr = '0;
    logic [56:0] lu_rdata;
    logic        cfg_req = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [56:0] cfg_wdata = '0;
    logic        cfg_ack;
    logic [56:0] cfg_rdata;
    logic        ram_rd;
    logic        ram_wr;
    logic [4:0]  ram_addr;
    logic [56:0] ram_wdata;
    logic [56:0] ram_rdata;
    logic        lookup_block;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [56:0] WDATA_A = 57'h1_0000_0000_0AAA;
    localparam logic [56:0] WDATA_B = 57'h0_1234_5678_9ABC;

    always #5 clk = ~clk;

    dmac_table_arbiter #(.STARVE_LIMIT(8'd4)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_lu_ram_rd     (lu_rd),
        .iv_lu_ram_raddr (lu_addr),
        .ov_lu_ram_rdata (lu_rdata),
        .i_cfg_req       (cfg_req),
        .i_cfg_wr        (cfg_wr),
        .iv_cfg_addr     (cfg_addr),
        .iv_cfg_wdata    (cfg_wdata),
        .o_cfg_ack       (cfg_ack),
        .ov_cfg_rdata    (cfg_rdata),
        .o_ram_rd        (ram_rd),
        .o_ram_wr        (ram_wr),
        .ov_ram_addr     (ram_addr),
        .ov_ram_wdata    (ram_wdata),
        .iv_ram_rdata    (ram_rdata),
        .o_lookup_block  (lookup_block)
    );

    // Unwritten RAM entries read back a fixed address-dependent pattern.
    function automatic logic [56:0] pre(input logic [4:0] a);
        return 57'h0_0055_AA00_0000 | {52'd0, a};
    endfunction

    // RAM model: write at the edge, read data visible two cycles after strobe.
    logic [56:0] mem [32];
    logic [31:0] written = '0;
    logic [56:0] s1 = '0;
    logic [56:0] s2 = '0;
    assign ram_rdata = s2;

    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr] = ram_wdata;
            written[ram_addr] = 1'b1;
        end
        if (ram_rd) s1 <= written[ram_addr] ? mem[ram_addr] : pre(ram_addr);
        else        s1 <= '0;
        s2 <= s1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) step();
        tests_run++; if (cfg_ack !== 1'b0) begin $display("FAIL rst_ack: got %b want 0", cfg_ack); tests_failed++; end
        tests_run++; if (cfg_rdata !== 57'd0) begin $display("FAIL rst_rdata: got %h want 0", cfg_rdata); tests_failed++; end
        tests_run++; if (lookup_block !== 1'b0) begin $display("FAIL rst_block: got %b want 0", lookup_block); tests_failed++; end
        tests_run++; if ({ram_rd, ram_wr} !== 2'b00) begin $display("FAIL rst_ram_strobes: got %b want 00", {ram_rd, ram_wr}); tests_failed++; end
        // RAM port follows lookup inputs while reset is held.
        lu_rd = 1'b1; lu_addr = 5'd12; cfg_req = 1'b1; #1;
        tests_run++; if (ram_rd !== 1'b1 || ram_addr !== 5'd12 || ram_wr !== 1'b0) begin
            $display("FAIL rst_lookup_follow: got rd=%b wr=%b addr=%0d want rd=1 wr=0 addr=12", ram_rd, ram_wr, ram_addr); tests_failed++; end
        lu_rd = 1'b0; lu_addr = '0; cfg_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cfg_write();
        cfg_req = 1'b1; cfg_wr = 1'b1; cfg_addr = 5'd3; cfg_wdata = WDATA_A; #1;
        tests_run++; if (ram_wr !== 1'b0) begin $display("FAIL wr_early: got %b want 0", ram_wr); tests_failed++; end
        step();
        tests_run++; if (ram_wr !== 1'b1 || ram_rd !== 1'b0) begin $display("FAIL wr_issue: got wr=%b rd=%b want wr=1 rd=0", ram_wr, ram_rd); tests_failed++; end
        tests_run++; if (ram_addr !== 5'd3 || ram_wdata !== WDATA_A) begin $display("FAIL wr_addr_data: got %0d/%h want 3/%h", ram_addr, ram_wdata, WDATA_A); tests_failed++; end
        tests_run++; if (cfg_ack !== 1'b0) begin $display("FAIL wr_ack_early: got %b want 0", cfg_ack); tests_failed++; end
        step();
        tests_run++; if (cfg_ack !== 1'b1) begin $display("FAIL wr_ack: got %b want 1", cfg_ack); tests_failed++; end
        tests_run++; if (ram_wr !== 1'b0) begin $display("FAIL wr_single: got %b want 0", ram_wr); tests_failed++; end
        cfg_req = 1'b0;
        step();
        tests_run++; if (cfg_ack !== 1'b0) begin $display("FAIL wr_ack_pulse: got %b want 0", cfg_ack); tests_failed++; end
    endtask

    task automatic test_cfg_read();
        cfg_req = 1'b1; cfg_wr = 1'b0; cfg_addr = 5'd3; cfg_wdata = '0;
        step();
        tests_run++; if (ram_rd !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 5'd3) begin
            $display("FAIL rd_issue: got rd=%b wr=%b addr=%0d want rd=1 wr=0 addr=3", ram_rd, ram_wr, ram_addr); tests_failed++; end
        step();
        tests_run++; if (cfg_ack !== 1'b0) begin $display("FAIL rd_ack_wait1: got %b want 0", cfg_ack); tests_failed++; end
        step();
        tests_run++; if (cfg_ack !== 1'b0) begin $display("FAIL rd_ack_wait2: got %b want 0", cfg_ack); tests_failed++; end
        step();
        tests_run++; if (cfg_ack !== 1'b1) begin $display("FAIL rd_ack: got %b want 1", cfg_ack); tests_failed++; end
        tests_run++; if (cfg_rdata !== WDATA_A) begin $display("FAIL rd_data: got %h want %h", cfg_rdata, WDATA_A); tests_failed++; end
        cfg_req = 1'b0;
        step();
        tests_run++; if (cfg_ack !== 1'b0 || cfg_rdata !== WDATA_A) begin
            $display("FAIL rd_hold: got ack=%b data=%h want ack=0 data=%h", cfg_ack, cfg_rdata, WDATA_A); tests_failed++; end
    endtask

    task automatic test_lookup_priority();
        cfg_req = 1'b1; cfg_wr = 1'b0; cfg_addr = 5'd7;
        step();
        lu_rd = 1'b1; lu_addr = 5'd9; #1;
        tests_run++; if (ram_rd !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 5'd9) begin
            $display("FAIL prio_lu1: got rd=%b wr=%b addr=%0d want rd=1 wr=0 addr=9", ram_rd, ram_wr, ram_addr); tests_failed++; end
        step();
        lu_addr = 5'd10; #1;
        tests_run++; if (ram_addr !== 5'd10) begin $display("FAIL prio_lu2: got addr=%0d want 10", ram_addr); tests_failed++; end
        step();
        lu_rd = 1'b0; lu_addr = '0; #1;
        tests_run++; if (ram_rd !== 1'b1 || ram_addr !== 5'd7) begin
            $display("FAIL prio_cfg_issue: got rd=%b addr=%0d want rd=1 addr=7", ram_rd, ram_addr); tests_failed++; end
        tests_run++; if (lu_rdata !== pre(5'd9)) begin $display("FAIL prio_lu_data9: got %h want %h", lu_rdata, pre(5'd9)); tests_failed++; end
        step();
        // Lookup read accepted while the config read is in flight.
        lu_rd = 1'b1; lu_addr = 5'd11; #1;
        tests_run++; if (lu_rdata !== pre(5'd10)) begin $display("FAIL prio_lu_data10: got %h want %h", lu_rdata, pre(5'd10)); tests_failed++; end
        tests_run++; if (ram_addr !== 5'd11 || ram_rd !== 1'b1) begin $display("FAIL prio_lu_inflight: got addr=%0d rd=%b want 11/1", ram_addr, ram_rd); tests_failed++; end
        step();
        lu_rd = 1'b0; lu_addr = '0; #1;
        tests_run++; if (cfg_ack !== 1'b0 || lookup_block !== 1'b0) begin
            $display("FAIL prio_wait2: got ack=%b block=%b want 0/0", cfg_ack, lookup_block); tests_failed++; end
        step();
        tests_run++; if (cfg_ack !== 1'b1 || cfg_rdata !== pre(5'd7)) begin
            $display("FAIL prio_cfg_data: got ack=%b data=%h want 1/%h", cfg_ack, cfg_rdata, pre(5'd7)); tests_failed++; end
        tests_run++; if (lu_rdata !== pre(5'd11)) begin $display("FAIL prio_lu_data11: got %h want %h", lu_rdata, pre(5'd11)); tests_failed++; end
        cfg_req = 1'b0;
        step();
        tests_run++; if (cfg_ack !== 1'b0) begin $display("FAIL prio_ack_pulse: got %b want 0", cfg_ack); tests_failed++; end
    endtask

`ifdef DMAC_ARB_STARVE_EN
    task automatic test_starve();
        cfg_req = 1'b1; cfg_wr = 1'b1; cfg_addr = 5'd4; cfg_wdata = WDATA_B;
        lu_rd = 1'b1; lu_addr = 5'd0;
        step();
        tests_run++; if (lookup_block !== 1'b0) begin $display("FAIL starve_block_w1: got %b want 0", lookup_block); tests_failed++; end
        repeat (3) step();
        tests_run++; if (lookup_block !== 1'b0) begin $display("FAIL starve_block_w4: got %b want 0", lookup_block); tests_failed++; end
        step();
        tests_run++; if (lookup_block !== 1'b1) begin $display("FAIL starve_block_set: got %b want 1", lookup_block); tests_failed++; end
        lu_rd = 1'b0; #1;
        tests_run++; if (ram_wr !== 1'b1 || ram_addr !== 5'd4 || ram_wdata !== WDATA_B) begin
            $display("FAIL starve_issue: got wr=%b addr=%0d data=%h want 1/4/%h", ram_wr, ram_addr, ram_wdata, WDATA_B); tests_failed++; end
        step();
        tests_run++; if (lookup_block !== 1'b0 || cfg_ack !== 1'b1) begin
            $display("FAIL starve_clear: got block=%b ack=%b want 0/1", lookup_block, cfg_ack); tests_failed++; end
        cfg_req = 1'b0;
        step();
    endtask
`endif

    task automatic test_reset_mid_op();
        cfg_req = 1'b1; cfg_wr = 1'b0; cfg_addr = 5'd3;
        repeat (3) step();
        // Now in CFG_RD_WAIT2.
        rst_n = 1'b0; cfg_req = 1'b0; #1;
        tests_run++; if ({cfg_ack, ram_rd, ram_wr, lookup_block} !== 4'b0000) begin
            $display("FAIL midrst_outputs: got ack/rd/wr/block=%b want 0000", {cfg_ack, ram_rd, ram_wr, lookup_block}); tests_failed++; end
        tests_run++; if (cfg_rdata !== 57'd0) begin $display("FAIL midrst_rdata: got %h want 0", cfg_rdata); tests_failed++; end
        repeat (2) step();
        tests_run++; if (cfg_ack !== 1'b0) begin $display("FAIL midrst_no_ack: got %b want 0", cfg_ack); tests_failed++; end
        rst_n = 1'b1;
        step();
        cfg_req = 1'b1; cfg_wr = 1'b0; cfg_addr = 5'd3;
        step();
        tests_run++; if (ram_rd !== 1'b1 || ram_addr !== 5'd3) begin
            $display("FAIL midrst_reissue: got rd=%b addr=%0d want 1/3", ram_rd, ram_addr); tests_failed++; end
        repeat (3) step();
        tests_run++; if (cfg_ack !== 1'b1 || cfg_rdata !== WDATA_A) begin
            $display("FAIL midrst_complete: got ack=%b data=%h want 1/%h", cfg_ack, cfg_rdata, WDATA_A); tests_failed++; end
        cfg_req = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cfg_write();
        test_cfg_read();
        test_lookup_priority();
`ifdef DMAC_ARB_STARVE_EN
        test_starve();
`endif
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
